// File: rtl/class_argmax.sv
// class_argmax: output stage that scans a packed vector of neuron outputs one
// element per clock and reports the index and value of the largest element.
//
// Ports:
//   s_axi_aclk     clock (rising edge)
//   s_axi_aresetn  synchronous reset, active low
//   i_data         packed input vector, element k = i_data[k*DATA_WIDTH +: DATA_WIDTH]
//   i_valid        input vector valid
//   i_ready        block can accept a vector (IDLE only)
//   o_class        index of the maximum element
//   o_max          value of the maximum element
//   o_valid        result valid
//   o_ready        consumer accepts the result
//   o_busy         scan in progress or result pending
//   intr           sticky result-ready interrupt
//   intr_clr       one-cycle interrupt clear
module class_argmax #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_IN     = 10,
  parameter int unsigned IDX_WIDTH  = 4,
  parameter bit          SIGNED     = 1'b1
) (
  input  logic                         s_axi_aclk,
  input  logic                         s_axi_aresetn,
  input  logic [NUM_IN*DATA_WIDTH-1:0] i_data,
  input  logic                         i_valid,
  output logic                         i_ready,
  output logic [IDX_WIDTH-1:0]         o_class,
  output logic [DATA_WIDTH-1:0]        o_max,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic                         o_busy,
  output logic                         intr,
  input  logic                         intr_clr
);

  localparam int unsigned SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_IN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                            state_q, state_d;
  logic [NUM_IN-1:0][DATA_WIDTH-1:0] vec_q, vec_d;
  logic [DATA_WIDTH-1:0]             run_max_q, run_max_d;
  logic [IDX_WIDTH-1:0]              run_idx_q, run_idx_d;
  logic [IDX_WIDTH-1:0]              cnt_q, cnt_d;

  logic [IDX_WIDTH-1:0]              class_d;
  logic [DATA_WIDTH-1:0]             max_d;
  logic                              valid_d;
  logic                              busy_d;
  logic                              ready_d;
  logic                              intr_d;
  logic                              set_intr;

  logic [DATA_WIDTH-1:0]             elem;
  logic                              win;
  logic [DATA_WIDTH-1:0]             fin_max;
  logic [IDX_WIDTH-1:0]              fin_idx;

  // Strict greater-than in the configured number format.
  function automatic logic greater(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b);
    if (SIGNED) greater = ($signed(a) > $signed(b));
    else        greater = (a > b);
  endfunction

  // Next-state, datapath and output logic.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    cnt_d     = cnt_q;
    class_d   = o_class;
    max_d     = o_max;
    valid_d   = o_valid;
    set_intr  = 1'b0;

    // Strict compare keeps the earlier index on ties.
    elem    = vec_q[SEL_W'(cnt_q)];
    win     = greater(elem, run_max_q);
    fin_max = win ? elem  : run_max_q;
    fin_idx = win ? cnt_q : run_idx_q;

    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          vec_d     = i_data;
          run_max_d = i_data[DATA_WIDTH-1:0];
          run_idx_d = '0;
          cnt_d     = IDX_WIDTH'(1);
          if (NUM_IN == 1) begin
            state_d  = DONE;
            class_d  = '0;
            max_d    = i_data[DATA_WIDTH-1:0];
            valid_d  = 1'b1;
            set_intr = 1'b1;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        run_max_d = fin_max;
        run_idx_d = fin_idx;
        cnt_d     = cnt_q + IDX_WIDTH'(1);
        if (cnt_q == LAST_IDX) begin
          state_d  = DONE;
          class_d  = fin_idx;
          max_d    = fin_max;
          valid_d  = 1'b1;
          set_intr = 1'b1;
        end
      end
      DONE: begin
        if (o_valid && o_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Set wins over a simultaneous clear.
    intr_d  = set_intr | (intr & ~intr_clr);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // Control and output registers.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state_q <= IDLE;
      o_class <= '0;
      o_max   <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      i_ready <= 1'b1;
      intr    <= 1'b0;
    end else begin
      state_q <= state_d;
      o_class <= class_d;
      o_max   <= max_d;
      o_valid <= valid_d;
      o_busy  <= busy_d;
      i_ready <= ready_d;
      intr    <= intr_d;
    end
  end

  // Scan datapath; contents only matter after a capture in IDLE.
  always_ff @(posedge s_axi_aclk) begin
    vec_q     <= vec_d;
    run_max_q <= run_max_d;
    run_idx_q <= run_idx_d;
    cnt_q     <= cnt_d;
  end

endmodule
